sparse_input_accumulator: RTL and testbench

Consumer end of the input-pixel queue. Pulls active-pixel indexes one at a time from the input queue register via its `dequeue`/`queueEmpty` handshake and fetches the weight row for each index from an external weight RAM. Adds each row element-wise into NODES signed accumulators, forming the first-layer pre-activation sums for the next layer. Because inactive pixels contribute nothing, only queued indexes are visited.

---
 rtl/sparse_input_accumulator.sv | 108 ++++++++++
 tb/tb_sparse_input_accumulator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sparse_input_accumulator.sv
// sparse_input_accumulator: pulls active-pixel indexes from the input queue,
// fetches each index's weight row from an external RAM and accumulates the
// rows element-wise into NODES saturating signed accumulators.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   start                 one-cycle run request, honoured only in IDLE
//   queue_empty, index_in queue status flag and head-of-queue index
//   dequeue               one-cycle queue pop strobe
//   weight_addr, weight_rd  weight RAM row address and read enable
//   weight_row            RAM read data, NODES packed signed elements
//   acc_out               NODES packed signed accumulators
//   index_count           indexes consumed in the current run
//   busy, done, sums_valid  run status
module sparse_input_accumulator #(
    parameter int NODES       = 10,
    parameter int WEIGHT_W    = 8,
    parameter int ACC_W       = 18,
    parameter int INPUT_NODES = 784
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      queue_empty,
    input  logic [9:0]                index_in,
    output logic                      dequeue,
    output logic [9:0]                weight_addr,
    output logic                      weight_rd,
    input  logic [NODES*WEIGHT_W-1:0] weight_row,
    output logic [NODES*ACC_W-1:0]    acc_out,
    output logic [9:0]                index_count,
    output logic                      busy,
    output logic                      done,
    output logic                      sums_valid
);

    typedef enum logic [2:0] {IDLE, CHECK, DEQ_HI, DEQ_LO, FETCH, ACCUM, DONE} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           state, state_next;
    logic [ACC_W-1:0] acc     [NODES];
    logic [ACC_W-1:0] acc_sat [NODES];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? CHECK : IDLE;
            CHECK:   state_next = (queue_empty || index_count == 10'(INPUT_NODES)) ? DONE : DEQ_HI;
            DEQ_HI:  state_next = DEQ_LO;
            DEQ_LO:  state_next = FETCH;
            FETCH:   state_next = ACCUM;
            ACCUM:   state_next = CHECK;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dequeue   = state == DEQ_HI;
        weight_rd = state == DEQ_LO;
        busy      = state != IDLE;
        done      = state == DONE;
    end

    // Sum at ACC_W+1 bits; a differing top pair of bits means overflow,
    // and the top bit then gives the direction to clamp.
    for (genvar n = 0; n < NODES; n++) begin : g_node
        logic [ACC_W:0] sum;
        assign sum = {acc[n][ACC_W-1], acc[n]}
                   + {{(ACC_W+1-WEIGHT_W){weight_row[n*WEIGHT_W+WEIGHT_W-1]}},
                      weight_row[n*WEIGHT_W +: WEIGHT_W]};
        assign acc_sat[n] = (sum[ACC_W] != sum[ACC_W-1]) ? (sum[ACC_W] ? ACC_MIN : ACC_MAX)
                                                         : sum[ACC_W-1:0];
        assign acc_out[n*ACC_W +: ACC_W] = acc[n];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NODES; n++) acc[n] <= '0;
            index_count <= '0;
            weight_addr <= '0;
            sums_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    for (int n = 0; n < NODES; n++) acc[n] <= '0;
                    index_count <= '0;
                    sums_valid  <= 1'b0;
                end
                DEQ_LO: weight_addr <= index_in;
                ACCUM: begin
                    for (int n = 0; n < NODES; n++) acc[n] <= acc_sat[n];
                    index_count <= index_count + 10'd1;
                end
                DONE:    sums_valid <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_input_accumulator.sv
// tb_sparse_input_accumulator: randomized and directed runs of the accumulator
// against a queue/RAM model and an arithmetic reference of the expected sums.
module tb_sparse_input_accumulator;
    localparam int NODES = 10;
    localparam int WW    = 8;

    logic clk = 0, reset = 1, start = 0;
    always #5 clk = ~clk;

    logic                queue_empty;
    logic [9:0]          index_in;
    logic                dequeue, weight_rd, busy, done, sums_valid;
    logic [9:0]          weight_addr, index_count;
    logic [NODES*WW-1:0] weight_row = '0;
    logic [NODES*18-1:0] acc_out;

    logic                s_dequeue, s_weight_rd, s_busy, s_done, s_sums_valid;
    logic [9:0]          s_weight_addr, s_index_count;
    logic [NODES*10-1:0] s_acc_out;

    sparse_input_accumulator #(.NODES(NODES), .WEIGHT_W(WW), .ACC_W(18), .INPUT_NODES(784)) u_dut (
        .clk(clk), .reset(reset), .start(start), .queue_empty(queue_empty), .index_in(index_in),
        .dequeue(dequeue), .weight_addr(weight_addr), .weight_rd(weight_rd), .weight_row(weight_row),
        .acc_out(acc_out), .index_count(index_count), .busy(busy), .done(done), .sums_valid(sums_valid));

    // Narrow-accumulator copy sharing the same queue and RAM, to reach saturation.
    sparse_input_accumulator #(.NODES(NODES), .WEIGHT_W(WW), .ACC_W(10), .INPUT_NODES(784)) u_sat (
        .clk(clk), .reset(reset), .start(start), .queue_empty(queue_empty), .index_in(index_in),
        .dequeue(s_dequeue), .weight_addr(s_weight_addr), .weight_rd(s_weight_rd), .weight_row(weight_row),
        .acc_out(s_acc_out), .index_count(s_index_count), .busy(s_busy), .done(s_done), .sums_valid(s_sums_valid));

    // Queue model: FIFO array, head advanced by the monitor, tail by the stimulus.
    logic [9:0] qmem [4096];
    int head = 0, tail = 0;
    assign queue_empty = head == tail;
    assign index_in    = qmem[head];

    // Weight RAM model: read enable registered, row returned on the following edge.
    int   ram [1024][NODES];
    logic rd_q = 0;
    always @(posedge clk) begin
        rd_q <= weight_rd;
        if (rd_q) for (int n = 0; n < NODES; n++) weight_row[n*WW +: WW] <= WW'(ram[weight_addr][n]);
    end

    // Monitor: pops the queue two cycles after a strobe, counts strobes/reads and spacing violations.
    int   deq_cnt = 0, rd_cnt = 0, wide_cnt = 0, gap = 10;
    logic d1 = 0, d2 = 0;
    always @(negedge clk) begin
        if (reset) begin
            d1 = 0;
            d2 = 0;
        end else begin
            if (d2) head = head + 1;
            d2 = d1;
            d1 = dequeue;
            if (dequeue) begin
                deq_cnt++;
                if (gap < 4) wide_cnt++;
                gap = 0;
            end else gap++;
            if (weight_rd) rd_cnt++;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v, input int w);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -hi - 1;
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction

    task automatic push(input int v);
        qmem[tail] = 10'(v);
        tail++;
    endtask

    // One run: expected sums are the clamped running totals of the queued rows,
    // taking at most 784 indexes; done is due 5k+2 cycles after start.
    task automatic run(input int mid);
        longint e18 [NODES];
        longint e10 [NODES];
        int first, k, c, d0, r0;
        first = head;
        k = (tail - head) > 784 ? 784 : tail - head;
        for (int n = 0; n < NODES; n++) begin
            e18[n] = 0;
            e10[n] = 0;
        end
        for (int i = 0; i < k; i++)
            for (int n = 0; n < NODES; n++) begin
                e18[n] = clamp(e18[n] + ram[qmem[first+i]][n], 18);
                e10[n] = clamp(e10[n] + ram[qmem[first+i]][n], 10);
            end
        d0 = deq_cnt;
        r0 = rd_cnt;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        c = 1;
        while (!done && c < 5000) begin
            @(posedge clk); #1;
            c++;
            start = (c == mid);
        end
        start = 0;
        chk("done_cycle", c, 5 * k + 2);
        chk("busy_in_done", busy, 1);
        @(posedge clk); #1;
        chk("sums_valid", sums_valid, 1);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("index_count", index_count, k);
        chk("sat_index_count", s_index_count, k);
        chk("dequeue_pulses", deq_cnt - d0, k);
        chk("weight_rd_pulses", rd_cnt - r0, k);
        chk("dequeue_spacing", wide_cnt, 0);
        for (int n = 0; n < NODES; n++) begin
            chk($sformatf("acc18[%0d]", n), $signed(acc_out[n*18 +: 18]), e18[n]);
            chk($sformatf("acc10[%0d]", n), $signed(s_acc_out[n*10 +: 10]), e10[n]);
        end
        tail = head;
    endtask

    initial begin
        int c;
        for (int i = 0; i < 1024; i++)
            for (int n = 0; n < NODES; n++) ram[i][n] = int'($urandom_range(255)) - 128;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        chk("rst_dequeue", dequeue, 0);
        chk("rst_weight_rd", weight_rd, 0);
        chk("rst_weight_addr", weight_addr, 0);
        chk("rst_acc_zero", acc_out == '0, 1);
        chk("rst_index_count", index_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sums_valid", sums_valid, 0);

        // Directed: rows of (i+1) for indexes 3, 7, 12.
        foreach (ram[3][n]) begin
            ram[3][n] = 4;
            ram[7][n] = 8;
            ram[12][n] = 13;
        end
        push(3); push(7); push(12);
        run(0);
        chk("directed_acc0", $signed(acc_out[17:0]), 25);

        // Empty queue at start.
        run(0);

        // Saturation of the narrow copy.
        for (int i = 100; i < 105; i++) begin
            ram[i][0] = 127;
            ram[i][1] = -128;
            push(i);
        end
        run(0);
        chk("sat_acc0", $signed(s_acc_out[9:0]), 511);
        chk("sat_acc1", $signed(s_acc_out[19:10]), -512);

        // Random runs, some with a stray start mid-run.
        for (int r = 0; r < 4; r++) begin
            int k = int'($urandom_range(12, 1));
            for (int i = 0; i < k; i++) push(int'($urandom_range(1023)));
            run(r[0] ? 8 : 0);
        end

        // Queue never empties within the run: capped at 784 indexes.
        for (int i = 0; i < 800; i++) push(int'($urandom_range(1023)));
        run(0);

        // Reset during the second index's dequeue strobe.
        push(5); push(9); push(11);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        c = 1;
        while (c < 7) begin
            @(posedge clk); #1;
            c++;
        end
        chk("pre_reset_dequeue", dequeue, 1);
        reset = 1;
        @(posedge clk); #1;
        chk("reset_dequeue", dequeue, 0);
        chk("reset_busy", busy, 0);
        chk("reset_acc_zero", acc_out == '0, 1);
        chk("reset_index_count", index_count, 0);
        reset = 0;
        tail = head;
        push(int'($urandom_range(1023)));
        push(int'($urandom_range(1023)));
        run(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
